// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions for the PRBS generator/checker pair.
package lfsr_pkg;

    // History/state width and the default feedback tap mask (bits 7,3,2,1).
    localparam int               LFSR_W       = 8;
    localparam logic [LFSR_W-1:0] DEFAULT_TAPS = 8'b1000_1110;

    // Checker state encoding.
    typedef enum logic [1:0] {
        ST_FILL   = 2'b00,
        ST_VERIFY = 2'b01,
        ST_LOCKED = 2'b10
    } chk_state_t;

endpackage

// File: rtl/lfsr_predict.sv
// Combinational next-bit prediction: parity of the tapped history bits.
module lfsr_predict
    import lfsr_pkg::*;
#(
    parameter int               W    = LFSR_W,
    parameter logic [W-1:0]     TAPS = DEFAULT_TAPS
) (
    input  logic [W-1:0] i_hist,
    output logic         o_pred
);

    assign o_pred = ^(i_hist & TAPS);

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: fills history, verifies a run of correct
// predictions, then flywheels on its own prediction and counts bit errors.
module prbs_checker
    import lfsr_pkg::*;
#(
    parameter logic [LFSR_W-1:0] TAPS        = DEFAULT_TAPS,
    parameter int                LOCK_COUNT  = 16,
    parameter int                LOSS_WINDOW = 64,
    parameter int                LOSS_THRESH = 8,
    parameter int                ERR_CNT_W   = 16
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 din_valid,
    input  logic                 din,
    input  logic                 clr_err,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int FILL_W = $clog2(LFSR_W);
    localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
    localparam int WIN_W  = (LOSS_WINDOW > 1) ? $clog2(LOSS_WINDOW) : 1;
    localparam int WERR_W = $clog2(LOSS_THRESH + 1);

    localparam logic [FILL_W-1:0] FILL_LAST   = FILL_W'(LFSR_W - 1);
    localparam logic [RUN_W-1:0]  RUN_LAST    = RUN_W'(LOCK_COUNT - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST    = WIN_W'(LOSS_WINDOW - 1);
    localparam logic [WERR_W-1:0] WERR_THRESH = WERR_W'(LOSS_THRESH);

    chk_state_t           r_state;
    chk_state_t           w_state_next;
    logic [LFSR_W-1:0]    r_hist;
    logic [FILL_W-1:0]    r_fill_cnt;
    logic [RUN_W-1:0]     r_run;
    logic [WIN_W-1:0]     r_win_cnt;
    logic [WERR_W-1:0]    r_win_err;
    logic                 r_locked;
    logic                 r_err_pulse;
    logic [ERR_CNT_W-1:0] r_err_count;

    logic                 w_pred;
    logic                 w_good;
    logic                 w_lock_err;
    logic                 w_wrap;
    logic [WERR_W-1:0]    w_win_err_next;

    lfsr_predict #(
        .W    (LFSR_W),
        .TAPS (TAPS)
    ) u_predict (
        .i_hist (r_hist),
        .o_pred (w_pred)
    );

    // A zero history would predict zero forever, so it never counts as a match.
    assign w_good     = (din == w_pred) && (r_hist != '0);
    assign w_lock_err = din_valid && (r_state == ST_LOCKED) && (din != w_pred);
    assign w_wrap     = (r_win_cnt == WIN_LAST);
    // An error on the wrap bit belongs to the new window.
    assign w_win_err_next = (w_wrap ? '0 : r_win_err) + {{(WERR_W-1){1'b0}}, w_lock_err};

    // State register plus registered lock flag.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_state  <= ST_FILL;
            r_locked <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_locked <= (w_state_next == ST_LOCKED);
        end
    end

    // Next-state logic; idle cycles hold the state.
    always_comb begin
        w_state_next = r_state;
        if (din_valid) begin
            unique case (r_state)
                ST_FILL:   if (r_fill_cnt == FILL_LAST)          w_state_next = ST_VERIFY;
                ST_VERIFY: if (w_good && (r_run == RUN_LAST))    w_state_next = ST_LOCKED;
                ST_LOCKED: if (w_win_err_next == WERR_THRESH)    w_state_next = ST_FILL;
                default:                                         w_state_next = ST_FILL;
            endcase
        end
    end

    // History shift: received bits while acquiring, own prediction when locked.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_hist <= '0;
        end else if (din_valid) begin
            r_hist <= {r_hist[LFSR_W-2:0], (r_state == ST_LOCKED) ? w_pred : din};
        end
    end

    // Fill and run counters; both rest at zero outside their own state.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_fill_cnt <= '0;
            r_run      <= '0;
        end else if (din_valid) begin
            r_fill_cnt <= (r_state == ST_FILL) ? r_fill_cnt + FILL_W'(1) : '0;
            r_run      <= ((r_state == ST_VERIFY) && w_good) ? r_run + RUN_W'(1) : '0;
        end
    end

    // Loss-of-lock window: bit counter and per-window error count.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_win_cnt <= '0;
            r_win_err <= '0;
        end else if (din_valid) begin
            if (r_state == ST_LOCKED) begin
                r_win_cnt <= w_wrap ? '0 : r_win_cnt + WIN_W'(1);
                r_win_err <= w_win_err_next;
            end else begin
                r_win_cnt <= '0;
                r_win_err <= '0;
            end
        end
    end

    // Error pulse and saturating error counter; clear wins but keeps a same-cycle error.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_err_pulse <= w_lock_err;
            if (clr_err) begin
                r_err_count <= w_lock_err ? ERR_CNT_W'(1) : '0;
            end else if (w_lock_err && (r_err_count != '1)) begin
                r_err_count <= r_err_count + ERR_CNT_W'(1);
            end
        end
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker driven by a reference 8-bit PRBS generator.
module tb_prbs_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        din_valid;
    logic        din;
    logic        clr_err;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;

    logic [7:0]  gen;
    int          n_vec;
    int          n_err;

    always #5 clk = ~clk;

    prbs_checker dut (
        .clock     (clk),
        .rst       (rst),
        .din_valid (din_valid),
        .din       (din),
        .clr_err   (clr_err),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Next bit of the stimulus generator (x^8+x^4+x^3+x^2+1).
    task automatic gen_bit(output logic b);
        b   = ^(gen & 8'h8E);
        gen = {gen[6:0], b};
    endtask

    // One clock: apply inputs, then sample 1 time unit after the edge.
    task automatic send(input logic v, input logic b);
        din_valid = v;
        din       = b;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        din       = 1'b0;
        clr_err   = 1'b0;
    endtask

    task automatic send_clean(input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            gen_bit(b);
            send(1'b1, b);
        end
    endtask

    task automatic send_error;
        logic b;
        gen_bit(b);
        send(1'b1, ~b);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic b;
        logic seen_pulse;
        logic seen_lock;
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        din_valid = 1'b0;
        din       = 1'b0;
        clr_err   = 1'b0;
        gen       = 8'hA5;

        // Reset state
        #2;
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_pulse", 32'(err_pulse), 32'd0);
        check("rst_count", 32'(err_count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Error-free acquisition: locked visible after the 24th valid bit
        send_clean(23);
        check("lock_23", 32'(locked), 32'd0);
        send_clean(1);
        check("lock_24", 32'(locked), 32'd1);
        seen_pulse = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            gen_bit(b);
            send(1'b1, b);
            if (err_pulse) seen_pulse = 1'b1;
        end
        check("clean_pulse", 32'(seen_pulse), 32'd0);
        check("clean_count", 32'(err_count), 32'd0);
        check("clean_locked", 32'(locked), 32'd1);

        // Single inverted bit
        send_error();
        check("single_pulse", 32'(err_pulse), 32'd1);
        check("single_count", 32'(err_count), 32'd1);
        check("single_locked", 32'(locked), 32'd1);
        send_clean(1);
        check("single_pulse_end", 32'(err_pulse), 32'd0);
        send_clean(20);
        check("single_after", 32'(err_count), 32'd1);

        // Idle cycle holds outputs
        send(1'b0, 1'b1);
        check("idle_locked", 32'(locked), 32'd1);
        check("idle_count", 32'(err_count), 32'd1);

        // clr_err alone, then error, then error coinciding with clear
        clr_err = 1'b1;
        send(1'b0, 1'b0);
        check("clr_alone", 32'(err_count), 32'd0);
        send_error();
        check("err_after_clr", 32'(err_count), 32'd1);
        send_error();
        check("back2back_pulse", 32'(err_pulse), 32'd1);
        check("back2back_count", 32'(err_count), 32'd2);
        clr_err = 1'b1;
        send_error();
        check("clr_with_err", 32'(err_count), 32'd1);

        // Asynchronous reset while locked
        #2;
        rst = 1'b1;
        #1;
        check("async_locked", 32'(locked), 32'd0);
        check("async_count", 32'(err_count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Relock after reset, then 8 errors spaced 5 bits apart
        send_clean(24);
        check("relock_rst", 32'(locked), 32'd1);
        for (int k = 0; k <= 35; k++) begin
            if (k % 5 == 0) send_error();
            else            send_clean(1);
            if (k == 30) check("burst_7_locked", 32'(locked), 32'd1);
        end
        check("burst_8_locked", 32'(locked), 32'd0);
        check("burst_8_pulse", 32'(err_pulse), 32'd1);
        check("burst_8_count", 32'(err_count), 32'd8);
        send_clean(23);
        check("reacq_23", 32'(locked), 32'd0);
        send_clean(1);
        check("reacq_24", 32'(locked), 32'd1);
        check("reacq_count", 32'(err_count), 32'd8);

        // All-zero stream never locks
        do_reset();
        seen_lock = 1'b0;
        for (int i = 0; i < 200; i++) begin
            send(1'b1, 1'b0);
            if (locked) seen_lock = 1'b1;
        end
        check("zero_lock", 32'(seen_lock), 32'd0);
        check("zero_count", 32'(err_count), 32'd0);

        // Valid toggling 1-0-1-0: lock after 24 valid bits (48 cycles)
        do_reset();
        gen = 8'hA5;
        for (int i = 0; i < 23; i++) begin
            send_clean(1);
            send(1'b0, 1'b1);
        end
        check("toggle_23", 32'(locked), 32'd0);
        send_clean(1);
        check("toggle_24", 32'(locked), 32'd1);
        send(1'b0, 1'b1);
        check("toggle_idle_locked", 32'(locked), 32'd1);
        check("toggle_idle_pulse", 32'(err_pulse), 32'd0);
        check("toggle_idle_count", 32'(err_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
